// File: rtl/rv32i_pkg.sv
// RV32I decode constants: opcodes, instruction classes and exception codes.
package rv32i_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

   typedef enum logic [3:0] {
      LUI    = 4'd0,
      AUIPC  = 4'd1,
      JAL    = 4'd2,
      JALR   = 4'd3,
      BRANCH = 4'd4,
      LOAD   = 4'd5,
      STORE  = 4'd6,
      OP_IMM = 4'd7,
      OP     = 4'd8,
      FENCE  = 4'd9,
      SYSTEM = 4'd10,
      CSR    = 4'd11
   } ins_class_t;

   localparam logic [3:0] EXC_FETCH_ERR  = 4'd1;
   localparam logic [3:0] EXC_ILLEGAL    = 4'd2;
   localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
   localparam logic [3:0] EXC_ECALL_M    = 4'd11;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational RV32I immediate extraction selected by instruction class.
// The opcode bits never contribute to an immediate, so only ins[31:7] comes in.
module id_imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7] ins,
   input  logic [3:0]  cls,
   output logic [31:0] imm_c
);

   always_comb begin
      imm_c = '0;
      case (ins_class_t'(cls))
         LUI, AUIPC: imm_c = {ins[31:12], 12'b0};
         JAL:        imm_c = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         BRANCH:     imm_c = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         STORE:      imm_c = {{21{ins[31]}}, ins[30:25], ins[11:7]};
         OP:         imm_c = '0;
         // JALR, LOAD, OP_IMM, FENCE, SYSTEM and CSR all use the I format
         default:    imm_c = {{21{ins[31]}}, ins[30:20]};
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage between the prefetch unit and execute: decodes one fetch
// per cycle into a single output register and drains wrong-path fetches.
module id_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned C_XLEN = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clk_en_i,
   input  logic              pfu_dav_i,
   output logic              pfu_ack_o,
   input  logic              pfu_sofr_i,
   input  logic [31:0]       pfu_ins_i,
   input  logic              pfu_ferr_i,
   input  logic [C_XLEN-1:0] pfu_pc_i,
   input  logic              flush_i,
   output logic              exs_valid_o,
   input  logic              exs_ready_i,
   output logic [C_XLEN-1:0] exs_pc_o,
   output logic [3:0]        exs_class_o,
   output logic [2:0]        exs_funct3_o,
   output logic              exs_alt_o,
   output logic [REG_W-1:0]  exs_rs1_o,
   output logic [REG_W-1:0]  exs_rs2_o,
   output logic [REG_W-1:0]  exs_rd_o,
   output logic              exs_rd_we_o,
   output logic [31:0]       exs_imm_o,
   output logic              exs_excp_o,
   output logic [3:0]        exs_excp_code_o
);

   typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t           state;
   ins_class_t       cls_c;
   logic             illegal_c;
   logic             excp_c;
   logic [3:0]       excp_code_c;
   logic             rd_we_c;
   logic             load_c;
   logic [31:0]      imm_c;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [REG_W-1:0] rd;

   assign opcode = pfu_ins_i[6:0];
   assign funct3 = pfu_ins_i[14:12];
   assign funct7 = pfu_ins_i[31:25];
   assign rd     = pfu_ins_i[11:7];

   // Class and legality; unknown opcodes (including ins[1:0] != 2'b11) are illegal
   always_comb begin
      cls_c     = OP_IMM;
      illegal_c = 1'b0;
      case (opcode)
         OPC_LUI:    cls_c = LUI;
         OPC_AUIPC:  cls_c = AUIPC;
         OPC_JAL:    cls_c = JAL;
         OPC_JALR: begin
            cls_c     = JALR;
            illegal_c = (funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            cls_c     = BRANCH;
            illegal_c = (funct3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            cls_c     = LOAD;
            illegal_c = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            cls_c     = STORE;
            illegal_c = (funct3 > 3'd2);
         end
         OPC_OP_IMM: begin
            cls_c = OP_IMM;
            if (funct3 == 3'd1)
               illegal_c = (funct7 != 7'h00);
            else if (funct3 == 3'd5)
               illegal_c = (funct7 != 7'h00) && (funct7 != 7'h20);
         end
         OPC_OP: begin
            cls_c     = OP;
            illegal_c = !((funct7 == 7'h00) ||
                          ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
         end
         OPC_MISC_MEM: begin
            cls_c     = FENCE;
            illegal_c = (funct3 > 3'd1);
         end
         OPC_SYSTEM: begin
            if (funct3 == 3'd0) begin
               cls_c     = SYSTEM;
               illegal_c = (pfu_ins_i != INS_ECALL) && (pfu_ins_i != INS_EBREAK);
            end else begin
               cls_c     = CSR;
               illegal_c = (funct3 == 3'd4);
            end
         end
         default: illegal_c = 1'b1;
      endcase
   end

   // Exception priority: bus error, illegal, breakpoint, environment call
   always_comb begin
      excp_c      = 1'b1;
      excp_code_c = 4'd0;
      if (pfu_ferr_i)
         excp_code_c = EXC_FETCH_ERR;
      else if (illegal_c)
         excp_code_c = EXC_ILLEGAL;
      else if (pfu_ins_i == INS_EBREAK)
         excp_code_c = EXC_BREAKPOINT;
      else if (pfu_ins_i == INS_ECALL)
         excp_code_c = EXC_ECALL_M;
      else
         excp_c = 1'b0;
   end

   always_comb begin
      rd_we_c = 1'b0;
      case (cls_c)
         LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, CSR:
            rd_we_c = (rd != 5'd0) && !excp_c;
         default: rd_we_c = 1'b0;
      endcase
   end

   id_imm_gen u_imm_gen (
      .ins   (pfu_ins_i[31:7]),
      .cls   (4'(cls_c)),
      .imm_c (imm_c)
   );

   // In DRAIN every fetch is accepted so wrong-path words are swallowed
   assign pfu_ack_o = clk_en_i & pfu_dav_i & ~flush_i &
                      (~exs_valid_o | exs_ready_i | (state == ST_DRAIN));
   assign load_c    = pfu_ack_o & ((state == ST_RUN) | pfu_sofr_i);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state           <= ST_DRAIN;
         exs_valid_o     <= 1'b0;
         exs_pc_o        <= '0;
         exs_class_o     <= '0;
         exs_funct3_o    <= '0;
         exs_alt_o       <= 1'b0;
         exs_rs1_o       <= '0;
         exs_rs2_o       <= '0;
         exs_rd_o        <= '0;
         exs_rd_we_o     <= 1'b0;
         exs_imm_o       <= '0;
         exs_excp_o      <= 1'b0;
         exs_excp_code_o <= '0;
      end else if (clk_en_i) begin
         if (flush_i) begin
            state       <= ST_DRAIN;
            exs_valid_o <= 1'b0;
         end else if (load_c) begin
            state           <= excp_c ? ST_DRAIN : ST_RUN;
            exs_valid_o     <= 1'b1;
            exs_pc_o        <= pfu_pc_i;
            exs_class_o     <= 4'(cls_c);
            exs_funct3_o    <= funct3;
            exs_alt_o       <= pfu_ins_i[30];
            exs_rs1_o       <= pfu_ins_i[19:15];
            exs_rs2_o       <= pfu_ins_i[24:20];
            exs_rd_o        <= rd;
            exs_rd_we_o     <= rd_we_c;
            exs_imm_o       <= imm_c;
            exs_excp_o      <= excp_c;
            exs_excp_code_o <= excp_code_c;
         end else if (exs_ready_i) begin
            exs_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a reference decoder plus a per-cycle
// handshake model, with directed vectors and hand-computed spot values.
module tb_id_stage;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        clk_en_i = 1'b1;
   logic        pfu_dav_i = 1'b0;
   logic        pfu_ack_o;
   logic        pfu_sofr_i = 1'b0;
   logic [31:0] pfu_ins_i = '0;
   logic        pfu_ferr_i = 1'b0;
   logic [31:0] pfu_pc_i = '0;
   logic        flush_i = 1'b0;
   logic        exs_valid_o;
   logic        exs_ready_i = 1'b0;
   logic [31:0] exs_pc_o;
   logic [3:0]  exs_class_o;
   logic [2:0]  exs_funct3_o;
   logic        exs_alt_o;
   logic [4:0]  exs_rs1_o, exs_rs2_o, exs_rd_o;
   logic        exs_rd_we_o;
   logic [31:0] exs_imm_o;
   logic        exs_excp_o;
   logic [3:0]  exs_excp_code_o;

   int n_checks = 0;
   int n_errors = 0;
   int ack_cnt  = 0;
   bit mon_on   = 1'b0;

   always #5 clk = ~clk;

   id_stage #(.C_XLEN(32)) dut (
      .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
      .pfu_dav_i(pfu_dav_i), .pfu_ack_o(pfu_ack_o), .pfu_sofr_i(pfu_sofr_i),
      .pfu_ins_i(pfu_ins_i), .pfu_ferr_i(pfu_ferr_i), .pfu_pc_i(pfu_pc_i),
      .flush_i(flush_i), .exs_valid_o(exs_valid_o), .exs_ready_i(exs_ready_i),
      .exs_pc_o(exs_pc_o), .exs_class_o(exs_class_o), .exs_funct3_o(exs_funct3_o),
      .exs_alt_o(exs_alt_o), .exs_rs1_o(exs_rs1_o), .exs_rs2_o(exs_rs2_o),
      .exs_rd_o(exs_rd_o), .exs_rd_we_o(exs_rd_we_o), .exs_imm_o(exs_imm_o),
      .exs_excp_o(exs_excp_o), .exs_excp_code_o(exs_excp_code_o)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [3:0]  cls;
      logic [2:0]  f3;
      logic        alt;
      logic [4:0]  rs1, rs2, rd;
      logic        rd_we;
      logic        excp;
      logic [3:0]  code;
      bit          skip;   // unknown opcode: class/imm unspecified
   } exp_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decoder built from the ISA tables with arithmetic sign extension
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic ferr,
                                       input logic [31:0] pc);
      exp_t e;
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      logic signed [31:0] s, t20, t25, t31;
      logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, u25, u31;
      bit legal, writes;
      s     = $signed(ins);
      t20   = s >>> 20;
      t25   = s >>> 25;
      t31   = s >>> 31;
      u25   = t25;
      u31   = t31;
      i_imm = t20;
      s_imm = (u25 << 5) | 32'(ins[11:7]);
      b_imm = (u31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      u_imm = ins & 32'hFFFF_F000;
      j_imm = (u31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      e.skip = 1'b0;
      legal  = 1'b1;
      e.imm  = i_imm;
      e.cls  = 4'(OP_IMM);
      case (op)
         7'h37: begin e.cls = 4'(LUI);   e.imm = u_imm; end
         7'h17: begin e.cls = 4'(AUIPC); e.imm = u_imm; end
         7'h6F: begin e.cls = 4'(JAL);   e.imm = j_imm; end
         7'h67: begin e.cls = 4'(JALR);  legal = (f3 == 3'd0); end
         7'h63: begin e.cls = 4'(BRANCH); e.imm = b_imm; legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7}; end
         7'h03: begin e.cls = 4'(LOAD);  legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
         7'h23: begin e.cls = 4'(STORE); e.imm = s_imm; legal = f3 inside {3'd0, 3'd1, 3'd2}; end
         7'h13: begin
            e.cls = 4'(OP_IMM);
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = f7 inside {7'h00, 7'h20};
         end
         7'h33: begin
            e.cls = 4'(OP); e.imm = 32'd0;
            legal = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5}));
         end
         7'h0F: begin e.cls = 4'(FENCE); legal = f3 inside {3'd0, 3'd1}; end
         7'h73: begin
            if (f3 == 3'd0) begin
               e.cls = 4'(SYSTEM);
               legal = (ins == 32'h0000_0073) || (ins == 32'h0010_0073);
            end else begin
               e.cls = 4'(CSR);
               legal = (f3 != 3'd4);
            end
         end
         default: begin legal = 1'b0; e.skip = 1'b1; end
      endcase
      if (ferr)                       e.code = 4'd1;
      else if (!legal)                e.code = 4'd2;
      else if (ins == 32'h0010_0073)  e.code = 4'd3;
      else if (ins == 32'h0000_0073)  e.code = 4'd11;
      else                            e.code = 4'd0;
      e.excp  = (e.code != 4'd0);
      writes  = e.cls inside {4'(LUI), 4'(AUIPC), 4'(JAL), 4'(JALR), 4'(LOAD), 4'(OP_IMM), 4'(OP), 4'(CSR)};
      e.rd    = ins[11:7];
      e.rs1   = ins[19:15];
      e.rs2   = ins[24:20];
      e.f3    = f3;
      e.alt   = ins[30];
      e.pc    = pc;
      e.rd_we = writes && (e.rd != 5'd0) && !e.excp;
      return e;
   endfunction

   // Model state: output register contents, valid flag and draining flag
   exp_t m_out = '{pc: 0, imm: 0, cls: 0, f3: 0, alt: 0, rs1: 0, rs2: 0, rd: 0,
                   rd_we: 0, excp: 0, code: 0, skip: 0};
   bit   m_valid = 1'b0;
   bit   m_drain = 1'b1;

   always @(negedge clk) begin
      if (mon_on) begin
         bit exp_ack;
         exp_ack = clk_en_i && pfu_dav_i && !flush_i && (!m_valid || exs_ready_i || m_drain);
         chk("ack", 32'(pfu_ack_o), 32'(exp_ack));
         chk("valid", 32'(exs_valid_o), 32'(m_valid));
         chk("pc", exs_pc_o, m_out.pc);
         chk("funct3", 32'(exs_funct3_o), 32'(m_out.f3));
         chk("alt", 32'(exs_alt_o), 32'(m_out.alt));
         chk("rs1", 32'(exs_rs1_o), 32'(m_out.rs1));
         chk("rs2", 32'(exs_rs2_o), 32'(m_out.rs2));
         chk("rd", 32'(exs_rd_o), 32'(m_out.rd));
         chk("rd_we", 32'(exs_rd_we_o), 32'(m_out.rd_we));
         chk("excp", 32'(exs_excp_o), 32'(m_out.excp));
         chk("excp_code", 32'(exs_excp_code_o), 32'(m_out.code));
         if (!m_out.skip) begin
            chk("class", 32'(exs_class_o), 32'(m_out.cls));
            chk("imm", exs_imm_o, m_out.imm);
         end
         if (pfu_ack_o === 1'b1) ack_cnt++;
         if (reset_i) begin
            m_valid = 1'b0;
            m_drain = 1'b1;
            m_out   = '{pc: 0, imm: 0, cls: 0, f3: 0, alt: 0, rs1: 0, rs2: 0, rd: 0,
                        rd_we: 0, excp: 0, code: 0, skip: 0};
         end else if (clk_en_i) begin
            if (flush_i) begin
               m_valid = 1'b0;
               m_drain = 1'b1;
            end else if (exp_ack && (!m_drain || pfu_sofr_i)) begin
               m_out   = ref_decode(pfu_ins_i, pfu_ferr_i, pfu_pc_i);
               m_valid = 1'b1;
               m_drain = m_out.excp;
            end else if (exs_ready_i) begin
               m_valid = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic dav, input logic sofr, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ferr, input logic rdy,
                        input logic fl);
      pfu_dav_i   = dav;
      pfu_sofr_i  = sofr;
      pfu_ins_i   = ins;
      pfu_pc_i    = pc;
      pfu_ferr_i  = ferr;
      exs_ready_i = rdy;
      flush_i     = fl;
   endtask

   localparam logic [31:0] ADDI   = 32'h0050_0093;
   localparam logic [31:0] ADDI10 = 32'h00A0_0113;
   localparam logic [31:0] BEQ    = 32'hFE20_8EE3;
   localparam logic [31:0] LUI5   = 32'h1234_52B7;
   localparam logic [31:0] ADD    = 32'h0020_81B3;

   localparam int NSWEEP = 22;
   localparam logic [31:0] SWEEP [NSWEEP] = '{
      32'h0080_00EF, 32'h0000_80E7, 32'h0000_90E7, 32'h0020_C463, 32'h0020_A463,
      32'h0040_A183, 32'h0040_B183, 32'h0020_A223, 32'h0020_B223, 32'h4020_81B3,
      32'h4020_91B3, 32'h0220_81B3, 32'h4030_D093, 32'h4030_9093, 32'h0FF0_000F,
      32'h0000_200F, 32'h3002_9073, 32'h0000_C073, 32'h3020_0073, 32'hFFFF_F097,
      32'h0000_0001, 32'hFE20_AE23
   };

   initial begin
      int a0;
      drive(0, 0, 32'd0, 32'd0, 0, 0, 0);
      reset_i = 1'b1;
      tick();
      tick();
      mon_on = 1'b1;
      chk("rst_valid", 32'(exs_valid_o), 32'd0);
      chk("rst_ack", 32'(pfu_ack_o), 32'd0);
      chk("rst_pc", exs_pc_o, 32'd0);
      chk("rst_imm", exs_imm_o, 32'd0);
      reset_i = 1'b0;

      // First fetch after reset carries sofr
      drive(1, 1, ADDI, 32'h100, 0, 1, 0);
      tick();
      chk("addi_valid", 32'(exs_valid_o), 32'd1);
      chk("addi_class", 32'(exs_class_o), 32'd7);
      chk("addi_rd", 32'(exs_rd_o), 32'd1);
      chk("addi_rs1", 32'(exs_rs1_o), 32'd0);
      chk("addi_imm", exs_imm_o, 32'h5);
      chk("addi_rd_we", 32'(exs_rd_we_o), 32'd1);
      chk("addi_pc", exs_pc_o, 32'h100);

      drive(1, 0, BEQ, 32'h104, 0, 1, 0);
      tick();
      chk("beq_imm", exs_imm_o, 32'hFFFF_FFFC);
      chk("beq_rs1", 32'(exs_rs1_o), 32'd1);
      chk("beq_rs2", 32'(exs_rs2_o), 32'd2);
      chk("beq_rd_we", 32'(exs_rd_we_o), 32'd0);
      chk("beq_excp", 32'(exs_excp_o), 32'd0);

      // Stall: one ack, outputs held three cycles, then no-bubble replacement
      a0 = ack_cnt;
      drive(1, 0, LUI5, 32'h108, 0, 1, 0);
      tick();
      chk("lui_imm", exs_imm_o, 32'h1234_5000);
      chk("lui_rd", 32'(exs_rd_o), 32'd5);
      drive(1, 0, ADD, 32'h10C, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc", exs_pc_o, 32'h108);
         chk("stall_valid", 32'(exs_valid_o), 32'd1);
      end
      chk("stall_acks", 32'(ack_cnt - a0), 32'd1);
      exs_ready_i = 1'b1;
      #1;
      chk("resume_ack", 32'(pfu_ack_o), 32'd1);
      tick();
      chk("resume_pc", exs_pc_o, 32'h10C);
      chk("resume_valid", 32'(exs_valid_o), 32'd1);

      // Illegal instruction, drop wrong-path fetches until sofr
      drive(1, 0, 32'h0, 32'h200, 0, 1, 0);
      tick();
      chk("ill_excp", 32'(exs_excp_o), 32'd1);
      chk("ill_code", 32'(exs_excp_code_o), 32'd2);
      chk("ill_rd_we", 32'(exs_rd_we_o), 32'd0);
      a0 = ack_cnt;
      drive(1, 0, ADDI, 32'h204, 0, 1, 0);
      tick();
      chk("drop1_valid", 32'(exs_valid_o), 32'd0);
      drive(1, 0, ADDI, 32'h208, 0, 1, 0);
      tick();
      chk("drop2_valid", 32'(exs_valid_o), 32'd0);
      chk("drop_acks", 32'(ack_cnt - a0), 32'd2);
      drive(1, 1, ADDI10, 32'h300, 0, 1, 0);
      tick();
      chk("sofr_valid", 32'(exs_valid_o), 32'd1);
      chk("sofr_pc", exs_pc_o, 32'h300);
      chk("sofr_imm", exs_imm_o, 32'd10);

      // Fetch error beats ECALL; then ECALL and EBREAK from sofr fetches
      drive(1, 0, 32'h0000_0073, 32'h304, 1, 1, 0);
      tick();
      chk("ferr_code", 32'(exs_excp_code_o), 32'd1);
      chk("ferr_rd_we", 32'(exs_rd_we_o), 32'd0);
      drive(1, 1, 32'h0000_0073, 32'h400, 0, 1, 0);
      tick();
      chk("ecall_code", 32'(exs_excp_code_o), 32'd11);
      drive(1, 1, 32'h0010_0073, 32'h404, 0, 1, 0);
      tick();
      chk("ebreak_code", 32'(exs_excp_code_o), 32'd3);
      drive(1, 1, ADDI, 32'h500, 0, 1, 0);
      tick();

      // Flush while valid with a fetch pending
      drive(1, 0, ADD, 32'h504, 0, 1, 1);
      #1;
      chk("flush_noack", 32'(pfu_ack_o), 32'd0);
      tick();
      chk("flush_valid", 32'(exs_valid_o), 32'd0);
      drive(1, 0, ADDI, 32'h508, 0, 1, 0);
      tick();
      chk("postflush_drop", 32'(exs_valid_o), 32'd0);
      drive(1, 1, ADDI, 32'h600, 0, 0, 0);
      tick();
      chk("refill_pc", exs_pc_o, 32'h600);

      // Clock enable low freezes everything
      clk_en_i = 1'b0;
      drive(1, 0, ADD, 32'h604, 0, 1, 1);
      tick();
      chk("cken_pc", exs_pc_o, 32'h600);
      chk("cken_valid", 32'(exs_valid_o), 32'd1);
      clk_en_i = 1'b1;

      // Flush while stalled
      drive(1, 0, ADD, 32'h604, 0, 0, 1);
      tick();
      chk("stallflush_valid", 32'(exs_valid_o), 32'd0);

      // Reset mid-stream
      drive(1, 1, ADD, 32'h608, 0, 1, 0);
      tick();
      reset_i = 1'b1;
      drive(1, 0, LUI5, 32'h60C, 0, 0, 0);
      tick();
      reset_i = 1'b0;
      chk("mrst_valid", 32'(exs_valid_o), 32'd0);
      chk("mrst_pc", exs_pc_o, 32'd0);
      chk("mrst_rd", 32'(exs_rd_o), 32'd0);
      chk("mrst_imm", exs_imm_o, 32'd0);
      drive(1, 0, ADDI, 32'h610, 0, 1, 0);
      tick();
      chk("mrst_drain", 32'(exs_valid_o), 32'd0);

      // Legality and format sweep, mixed ready pattern
      for (int i = 0; i < NSWEEP; i++) begin
         drive(1, 1, SWEEP[i], 32'h700 + 32'(i * 4), 0, (i % 3) != 1, 0);
         tick();
      end
      for (int i = 0; i < NSWEEP; i++) begin
         drive(1, (i % 4) == 0, SWEEP[i], 32'h800 + 32'(i * 4), (i == 7), (i % 2) == 0, (i == 13));
         tick();
      end
      drive(0, 0, 32'd0, 32'd0, 0, 1, 0);
      tick();
      tick();
      mon_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction decode stage, directly downstream of the prefetch unit (pfu).
- Consumes pfu fetches through the dav/ack handshake and decodes register indices, immediates, instruction class and exceptions.
- Holds the decoded result in a single output register feeding the execute stage through a valid/ready handshake.
- Discards wrong-path fetches after an exception or a flush until the pfu marks the first fetch since vectoring (sofr).

Parameters:
- C_XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- clk_en_i  in  1  clock enable; when low, state and outputs hold
- pfu_dav_i  in  1  fetch available
- pfu_ack_o  out  1  accept the current fetch
- pfu_sofr_i  in  1  first fetch since vectoring
- pfu_ins_i  in  32  instruction word
- pfu_ferr_i  in  1  fetch bus error
- pfu_pc_i  in  32  address of the fetch
- flush_i  in  1  redirect from execute/vectoring; kill the stage
- exs_valid_o  out  1  decoded instruction valid
- exs_ready_i  in  1  execute stage accepts
- exs_pc_o  out  32  instruction address
- exs_class_o  out  4  instruction class (ins_class_t)
- exs_funct3_o  out  3  funct3 field
- exs_alt_o  out  1  ins[30] (SUB/SRA select)
- exs_rs1_o  out  5  source register 1 index
- exs_rs2_o  out  5  source register 2 index
- exs_rd_o  out  5  destination register index
- exs_rd_we_o  out  1  destination write enable
- exs_imm_o  out  32  sign-extended immediate
- exs_excp_o  out  1  exception flagged
- exs_excp_code_o  out  4  mcause code

Behaviour:
- Reset: all exs_* outputs are 0, pfu_ack_o is 0, state is DRAIN (the first fetch after reset carries sofr).
- Acceptance, combinational: pfu_ack_o = clk_en_i & pfu_dav_i & ~flush_i & (~exs_valid_o | exs_ready_i | state==DRAIN).
- Latency: one cycle from ack to exs_valid_o.
- Output register behaviour:
  - Loads on an ack in RUN, or on an ack in DRAIN with sofr=1.
  - Holds all fields stable while exs_valid_o & ~exs_ready_i.
  - Clears valid when exs_ready_i is high and no new load occurs.
- State machine:
  - RUN -> DRAIN when a decoded instruction with excp=1 is loaded. Subsequent fetches with sofr=0 are acked and dropped.
  - DRAIN -> RUN when a fetch with sofr=1 is acked; that fetch is decoded and loaded normally, including its own exception, which re-enters DRAIN.
  - flush_i in any state: next cycle exs_valid_o=0 and state=DRAIN; no ack in the flush cycle. flush_i overrides a simultaneous exs_ready_i or load.
- Simultaneous events: a consume and a load in the same cycle is legal; the register is replaced, giving full throughput.
- Exception priority:
  - pfu_ferr_i -> code 1.
  - Illegal instruction -> code 2.
  - EBREAK -> code 3.
  - ECALL -> code 11.
  - With excp=1, exs_rd_we_o is 0.
- Illegal conditions:
  - ins[1:0] != 2'b11, or opcode outside LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/OP-IMM/OP/MISC-MEM/SYSTEM.
  - JALR with funct3 != 0.
  - BRANCH with funct3 of 2 or 3.
  - LOAD with funct3 of 3, 6 or 7.
  - STORE with funct3 > 2.
  - OP with funct7 not 0x00/0x20, or funct7=0x20 with funct3 not 0 or 5.
  - OP-IMM shifts with bad funct7 (SLLI funct7 != 0; SRLI/SRAI funct7 not 0x00/0x20).
  - MISC-MEM with funct3 > 1.
  - SYSTEM with funct3=4; SYSTEM with funct3=0 other than exactly 0x00000073 or 0x00100073.
- Immediates:
  - Formats I/S/B/U/J per RV32I, sign bit always ins[31].
  - CSR instructions use the I-format immediate; the zimm is exs_rs1_o.
  - R-type gives imm = 0.
- rd_we: 1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP/CSR when rd != 0; otherwise 0.
- rs1/rs2/rd are always raw ins fields; the execute stage ignores unused ones.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants;
  - ins_class_t enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM, CSR;
  - exception code constants.
- Sub-module id_imm_gen: combinational immediate extraction (ins, class -> imm).
- The state machine and output register remain in id_stage.

Test Plan:
- addi x1,x0,5 (0x00500093) at pc 0x100, exs_ready_i=1 -> next cycle: valid=1, class=OP_IMM, rd=1, rs1=0, imm=0x5, rd_we=1, pc=0x100.
- beq x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0, excp=0.
- Back-to-back fetches with exs_ready_i=0 for 3 cycles -> one ack only, outputs stable 3 cycles; ready=1 -> second ack in the same cycle, no bubble.
- ins 0x00000000 -> excp=1, code=2. Two following fetches with sofr=0 -> acked, valid stays 0. Fetch with sofr=1 -> decoded and valid.
- pfu_ferr_i=1 with ins 0x00000073 -> code 1 (not 11).
- flush_i during valid with dav=1 -> pfu_ack_o=0 that cycle, valid=0 next cycle; reset_i mid-stream -> all outputs 0 and state DRAIN next cycle.
